// File: rtl/riscv_mstage.sv
// RV64I memory-access stage: one req/ack transaction per load or store on a
// doubleword data port, with store byte-lane alignment and load extension.
module riscv_mstage #(
    parameter int width = 64
) (
    input  logic             i_riscv_mstage_clk,
    input  logic             i_riscv_mstage_rst,
    input  logic [width-1:0] i_riscv_mstage_aluresult,
    input  logic [width-1:0] i_riscv_mstage_storedata,
    input  logic             i_riscv_mstage_memread,
    input  logic             i_riscv_mstage_memwrite,
    input  logic [2:0]       i_riscv_mstage_memext,
    output logic             o_riscv_mstage_dmem_req,
    output logic             o_riscv_mstage_dmem_we,
    output logic [width-1:0] o_riscv_mstage_dmem_addr,
    output logic [width-1:0] o_riscv_mstage_dmem_wdata,
    output logic [7:0]       o_riscv_mstage_dmem_be,
    input  logic             i_riscv_mstage_dmem_ack,
    input  logic [width-1:0] i_riscv_mstage_dmem_rdata,
    output logic [width-1:0] o_riscv_mstage_memload,
    output logic             o_riscv_mstage_stall,
    output logic             o_riscv_mstage_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    logic [2:0]       r_off;
    logic [2:0]       r_ext;
    logic             r_req;
    logic             r_we;
    logic [width-1:0] r_addr;
    logic [width-1:0] r_wdata;
    logic [7:0]       r_be;
    logic [width-1:0] r_memload;

    logic             w_is_mem;
    logic             w_reserved;
    logic             w_aligned;
    logic             w_pending;
    logic [2:0]       w_off;

    // The low two funct3 bits encode the access size (B/H/W/D) for both loads and stores.
    function automatic logic f_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return (off[0] == 1'b0);
            2'b10:   return (off[1:0] == 2'b00);
            2'b11:   return (off == 3'b000);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] f_store_be(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 8'h01 << off;
            2'b01:   return 8'h03 << off;
            2'b10:   return 8'h0F << off;
            2'b11:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [width-1:0] f_store_data(input logic [1:0] size,
                                                      input logic [width-1:0] sd);
        case (size)
            2'b00:   return {8{sd[7:0]}};
            2'b01:   return {4{sd[15:0]}};
            2'b10:   return {2{sd[31:0]}};
            2'b11:   return sd;
            default: return sd;
        endcase
    endfunction

    function automatic logic [width-1:0] f_load_ext(input logic [2:0] ext,
                                                    input logic [2:0] off,
                                                    input logic [width-1:0] rdata);
        logic [width-1:0] s;
        s = rdata >> {off, 3'b000};
        case (ext)
            3'b000:  return {{(width-8){s[7]}}, s[7:0]};
            3'b001:  return {{(width-16){s[15]}}, s[15:0]};
            3'b010:  return {{(width-32){s[31]}}, s[31:0]};
            3'b011:  return rdata;
            3'b100:  return {{(width-8){1'b0}}, s[7:0]};
            3'b101:  return {{(width-16){1'b0}}, s[15:0]};
            3'b110:  return {{(width-32){1'b0}}, s[31:0]};
            default: return rdata;
        endcase
    endfunction

    assign w_off      = i_riscv_mstage_aluresult[2:0];
    assign w_is_mem   = i_riscv_mstage_memread | i_riscv_mstage_memwrite;
    assign w_reserved = (i_riscv_mstage_memext == 3'b111);
    assign w_aligned  = f_aligned(i_riscv_mstage_memext[1:0], w_off);
    assign w_pending  = w_is_mem & ~w_reserved & w_aligned;

    assign o_riscv_mstage_misaligned = w_is_mem & ~w_reserved & ~w_aligned;
    // The pipeline is released only in DONE, so an instruction advances exactly once.
    assign o_riscv_mstage_stall      = ((r_state == S_IDLE) & w_pending) | (r_state == S_REQ);

    assign o_riscv_mstage_dmem_req   = r_req;
    assign o_riscv_mstage_dmem_we    = r_we;
    assign o_riscv_mstage_dmem_addr  = r_addr;
    assign o_riscv_mstage_dmem_wdata = r_wdata;
    assign o_riscv_mstage_dmem_be    = r_be;
    assign o_riscv_mstage_memload    = r_memload;

    // Access FSM together with the registered memory-port and load-result outputs.
    always_ff @(posedge i_riscv_mstage_clk or negedge i_riscv_mstage_rst) begin
        if (!i_riscv_mstage_rst) begin
            r_state   <= S_IDLE;
            r_off     <= 3'b000;
            r_ext     <= 3'b000;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= {width{1'b0}};
            r_wdata   <= {width{1'b0}};
            r_be      <= 8'h00;
            r_memload <= {width{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pending) begin
                        r_off   <= w_off;
                        r_ext   <= i_riscv_mstage_memext;
                        r_req   <= 1'b1;
                        r_we    <= i_riscv_mstage_memwrite;
                        r_addr  <= {i_riscv_mstage_aluresult[width-1:3], 3'b000};
                        r_wdata <= f_store_data(i_riscv_mstage_memext[1:0],
                                                i_riscv_mstage_storedata);
                        r_be    <= f_store_be(i_riscv_mstage_memext[1:0], w_off);
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (i_riscv_mstage_dmem_ack) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        // r_we still holds this access's direction at the ack edge.
                        if (!r_we) begin
                            r_memload <= f_load_ext(r_ext, r_off, i_riscv_mstage_dmem_rdata);
                        end else begin
                            r_memload <= r_memload;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mstage.sv
// Directed-vector bench for riscv_mstage with a bench-driven data-memory responder.
module tb_riscv_mstage;

    logic        clk;
    logic        rst;
    logic [63:0] aluresult;
    logic [63:0] storedata;
    logic        memread;
    logic        memwrite;
    logic [2:0]  memext;
    logic        req;
    logic        we;
    logic [63:0] daddr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        ack;
    logic [63:0] rdata;
    logic [63:0] memload;
    logic        stall;
    logic        misaligned;

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_stall;
    int          obs_reqc;
    int          obs_rises;
    logic        obs_stable;
    logic        obs_mis;
    logic        obs_done;
    logic        obs_req_end;
    logic        obs_we_end;
    logic [63:0] obs_addr;
    logic [63:0] obs_wdata;
    logic [7:0]  obs_be;
    logic        obs_we;
    logic [63:0] obs_load;

    riscv_mstage #(.width(64)) dut (
        .i_riscv_mstage_clk        (clk),
        .i_riscv_mstage_rst        (rst),
        .i_riscv_mstage_aluresult  (aluresult),
        .i_riscv_mstage_storedata  (storedata),
        .i_riscv_mstage_memread    (memread),
        .i_riscv_mstage_memwrite   (memwrite),
        .i_riscv_mstage_memext     (memext),
        .o_riscv_mstage_dmem_req   (req),
        .o_riscv_mstage_dmem_we    (we),
        .o_riscv_mstage_dmem_addr  (daddr),
        .o_riscv_mstage_dmem_wdata (wdata),
        .o_riscv_mstage_dmem_be    (be),
        .i_riscv_mstage_dmem_ack   (ack),
        .i_riscv_mstage_dmem_rdata (rdata),
        .o_riscv_mstage_memload    (memload),
        .o_riscv_mstage_stall      (stall),
        .o_riscv_mstage_misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one instruction (entered just after a rising edge) until the stage releases it.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] ext,
                          input logic [63:0] addr, input logic [63:0] sd,
                          input logic [63:0] rd_data, input int delay);
        int   cyc;
        logic prev_req;
        obs_stall = 0; obs_reqc = 0; obs_rises = 0; obs_stable = 1'b1;
        obs_mis = 1'b0; obs_done = 1'b0; prev_req = 1'b0; cyc = 0;
        memread = rd; memwrite = wr; memext = ext; aluresult = addr; storedata = sd;
        while (!obs_done && cyc < 20) begin
            @(negedge clk);
            if (cyc == 0) obs_mis = misaligned;
            if (stall) obs_stall++;
            if (req) begin
                if (!prev_req) begin
                    obs_rises++;
                    obs_addr = daddr; obs_wdata = wdata; obs_be = be; obs_we = we;
                end else if (daddr !== obs_addr || wdata !== obs_wdata || be !== obs_be || we !== obs_we) begin
                    obs_stable = 1'b0;
                end
                ack   = (obs_reqc == delay);
                rdata = rd_data;
                obs_reqc++;
            end
            prev_req = req;
            if (!stall) begin
                obs_done    = 1'b1;
                obs_load    = memload;
                obs_req_end = req;
                obs_we_end  = we;
            end
            @(posedge clk);
            #1;
            ack = 1'b0;
            cyc++;
        end
        check("op_completes", {63'd0, obs_done}, 64'd1);
        memread = 1'b0; memwrite = 1'b0; memext = 3'b000;
        aluresult = 64'd0; storedata = 64'd0;
    endtask

    initial begin
        rst = 1'b0; aluresult = 64'd0; storedata = 64'd0;
        memread = 1'b0; memwrite = 1'b0; memext = 3'b000;
        ack = 1'b0; rdata = 64'd0;
        #12;
        check("rst_req",     {63'd0, req}, 64'd0);
        check("rst_we",      {63'd0, we}, 64'd0);
        check("rst_addr",    daddr, 64'd0);
        check("rst_wdata",   wdata, 64'd0);
        check("rst_be",      {56'd0, be}, 64'd0);
        check("rst_memload", memload, 64'd0);
        check("rst_stall",   {63'd0, stall}, 64'd0);
        check("rst_mis",     {63'd0, misaligned}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // LB at offset 3, zero-wait
        run_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h1122_3344_8877_6655, 0);
        check("lb_addr",    obs_addr, 64'h1000);
        check("lb_we",      {63'd0, obs_we}, 64'd0);
        check("lb_be",      {56'd0, obs_be}, 64'h08);
        check("lb_load",    obs_load, 64'hFFFF_FFFF_FFFF_FF88);
        check("lb_stall",   obs_stall, 64'd2);
        check("lb_req_end", {63'd0, obs_req_end}, 64'd0);

        // LHU at offset 6
        run_op(1'b1, 1'b0, 3'b101, 64'h16, 64'd0, 64'hABCD_0000_0000_0000, 0);
        check("lhu_addr", obs_addr, 64'h10);
        check("lhu_load", obs_load, 64'h0000_0000_0000_ABCD);

        // SW at offset 4
        run_op(1'b0, 1'b1, 3'b010, 64'h2004, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        check("sw_addr",   obs_addr, 64'h2000);
        check("sw_we",     {63'd0, obs_we}, 64'd1);
        check("sw_be",     {56'd0, obs_be}, 64'hF0);
        check("sw_wdata",  obs_wdata, 64'hCAFE_F00D_CAFE_F00D);
        check("sw_load",   obs_load, 64'h0000_0000_0000_ABCD);
        check("sw_we_end", {63'd0, obs_we_end}, 64'd0);

        // SB at offset 5, memread and memwrite both set: treated as a store
        run_op(1'b1, 1'b1, 3'b000, 64'h7005, 64'h1234_5678_9ABC_DEA5, 64'd0, 0);
        check("sb_we",    {63'd0, obs_we}, 64'd1);
        check("sb_be",    {56'd0, obs_be}, 64'h20);
        check("sb_wdata", obs_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
        check("sb_load",  obs_load, 64'h0000_0000_0000_ABCD);

        // SD
        run_op(1'b0, 1'b1, 3'b011, 64'h7010, 64'h0102_0304_0506_0708, 64'd0, 0);
        check("sd_be",    {56'd0, obs_be}, 64'hFF);
        check("sd_wdata", obs_wdata, 64'h0102_0304_0506_0708);

        // Misaligned LW
        run_op(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 64'd0, 0);
        check("mis_flag",  {63'd0, obs_mis}, 64'd1);
        check("mis_reqc",  obs_reqc, 64'd0);
        check("mis_stall", obs_stall, 64'd0);
        check("mis_load",  obs_load, 64'h0000_0000_0000_ABCD);

        // Reserved funct3 and a non-memory instruction pass without any access
        run_op(1'b1, 1'b0, 3'b111, 64'h3000, 64'd0, 64'd0, 0);
        check("rsv_reqc",  obs_reqc, 64'd0);
        check("rsv_mis",   {63'd0, obs_mis}, 64'd0);
        check("rsv_stall", obs_stall, 64'd0);
        run_op(1'b0, 1'b0, 3'b011, 64'h3001, 64'd0, 64'd0, 0);
        check("nop_stall", obs_stall, 64'd0);
        check("nop_mis",   {63'd0, obs_mis}, 64'd0);

        // LD with three wait states
        run_op(1'b1, 1'b0, 3'b011, 64'h4008, 64'd0, 64'h0123_4567_89AB_CDEF, 3);
        check("ld_reqc",   obs_reqc, 64'd4);
        check("ld_stall",  obs_stall, 64'd5);
        check("ld_rises",  obs_rises, 64'd1);
        check("ld_stable", {63'd0, obs_stable}, 64'd1);
        check("ld_addr",   obs_addr, 64'h4008);
        check("ld_load",   obs_load, 64'h0123_4567_89AB_CDEF);

        // LW at offset 4 sign-extended, one wait state
        run_op(1'b1, 1'b0, 3'b010, 64'h5004, 64'd0, 64'h8000_0001_1111_2222, 1);
        check("lw_load",  obs_load, 64'hFFFF_FFFF_8000_0001);
        check("lw_stall", obs_stall, 64'd3);

        // WU at offset 4 zero-extended
        run_op(1'b1, 1'b0, 3'b110, 64'h5004, 64'd0, 64'h8000_0001_1111_2222, 0);
        check("lwu_load", obs_load, 64'h0000_0000_8000_0001);

        // Reset asserted while a request is outstanding
        memread = 1'b1; memwrite = 1'b0; memext = 3'b000; aluresult = 64'h6001;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_pre_req", {63'd0, req}, 64'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_req",     {63'd0, req}, 64'd0);
        check("rst_mid_memload", memload, 64'd0);
        memread = 1'b0;
        #1;
        check("rst_mid_stall",   {63'd0, stall}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        ack = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        check("late_ack_memload", memload, 64'd0);
        check("late_ack_req",     {63'd0, req}, 64'd0);
        check("late_ack_stall",   {63'd0, stall}, 64'd0);
        @(posedge clk); #1;

        // Recovery after reset: LH at offset 2 sign-extended
        run_op(1'b1, 1'b0, 3'b001, 64'h6002, 64'd0, 64'h0000_0000_9876_0000, 0);
        check("lh_load",  obs_load, 64'hFFFF_FFFF_FFFF_9876);
        check("lh_rises", obs_rises, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_mstage.md
# riscv_mstage

Memory-access stage of the RV64I five-stage pipeline, directly downstream of `riscv_estage`. It takes the ALU result (the effective address) and the forwarded rs2 store data from the E/M register. It runs one request/acknowledge transaction per load or store on a doubleword-wide data-memory port, aligns store data with byte enables, and extracts and sign- or zero-extends load data. While an access is outstanding it stalls the pipeline through the hazard unit.

## Interface
- `width`, 64: datapath and address width; only 64 is supported.

- `i_riscv_mstage_clk` in 1: clock, rising edge.
- `i_riscv_mstage_rst` in 1: asynchronous reset, active-low.
- `i_riscv_mstage_aluresult` in width: effective address from E/M register.
- `i_riscv_mstage_storedata` in width: forwarded rs2 data.
- `i_riscv_mstage_memread` in 1: instruction in M is a load.
- `i_riscv_mstage_memwrite` in 1: instruction in M is a store.
- `i_riscv_mstage_memext` in 3: funct3. 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 reserved.
- `o_riscv_mstage_dmem_req` out 1: request, registered.
- `o_riscv_mstage_dmem_we` out 1: 1 = write, registered.
- `o_riscv_mstage_dmem_addr` out width: doubleword-aligned address with [2:0]=0, registered.
- `o_riscv_mstage_dmem_wdata` out width: replicated store data, registered.
- `o_riscv_mstage_dmem_be` out 8: byte enables, registered.
- `i_riscv_mstage_dmem_ack` in 1: request accepted/completed. Read data is valid in the same cycle.
- `i_riscv_mstage_dmem_rdata` in width: read doubleword.
- `o_riscv_mstage_memload` out width: extended load result, registered.
- `o_riscv_mstage_stall` out 1: freeze F/D/E/M registers (combinational).
- `o_riscv_mstage_misaligned` out 1: misaligned-access flag (combinational).

## Operation
- **Access pending** when: (memread | memwrite), memext ≠ 111, and the address is aligned. If memread and memwrite are both 1, the access is a store.
- **Alignment rules:**
  - H/HU require addr[0]=0.
  - W/WU require addr[1:0]=0.
  - D requires addr[2:0]=0.
  - B is always aligned.
- **Misaligned access:** misaligned=1 while the instruction is present. No request is issued, stall=0, and memload is unchanged.
- **FSM states:**
  - **IDLE:**
    - If an access is pending, capture addr[2:0], memext and the write flag.
    - Load the dmem output registers: req=1, aligned addr, wdata, be, we.
    - Go to REQ.
    - stall = pending, combinationally.
  - **REQ:**
    - req held at 1; addr, we, wdata and be are stable.
    - stall=1.
    - On ack=1: clear req and we. For loads, register the extended data into memload. Go to DONE.
    - On ack=0: stay in REQ.
  - **DONE:**
    - stall=0 for exactly one cycle, so the pipeline advances at this edge.
    - Go to IDLE unconditionally. This prevents re-issuing the same instruction.
- **Store formatting** (o = addr[2:0]):
  - SB: wdata={8{rs2[7:0]}}, be=8'h01<<o.
  - SH: wdata={4{rs2[15:0]}}, be=8'h03<<o.
  - SW: wdata={2{rs2[31:0]}}, be=8'h0F<<o.
  - SD: wdata=rs2, be=8'hFF.
- **Load extraction:**
  - s = rdata >> (8·o).
  - B/H/W sign-extend s[7:0]/s[15:0]/s[31:0].
  - BU/HU/WU zero-extend.
  - D takes rdata as is.
- **memload retention:** memload holds its value until the next load completes. Stores and non-memory instructions do not change it.
- **Ignored ack:** ack is ignored in IDLE and DONE.

## Timing
- **Reset values:**
  - FSM=IDLE.
  - req=0, we=0, addr=0, wdata=0, be=0, memload=0.
  - stall and misaligned follow their combinational rules (state IDLE).
- **Reset behaviour:** reset is asynchronous in any state. An outstanding transaction is abandoned, and an ack arriving after reset is ignored.
- **Zero-wait memory:** the access occupies 3 cycles (IDLE, REQ with ack, DONE) with stall=1 for 2 of them. memload is valid from the DONE cycle.
- **N-cycle ack delay:** the access occupies N+3 cycles with N+2 stall cycles.
- **Handshake rule:** req never drops before ack, and req is never asserted in IDLE or DONE.
- **Back-to-back accesses:** the next access starts in the IDLE cycle following DONE. The minimum request spacing is 3 cycles.
- **Non-memory and misaligned instructions:** these pass in one cycle with no stall.

## Test plan
- **LB, sign-extended:** LB, addr=0x1003, rdata=0x1122_3344_8877_6655 with ack in the first REQ cycle.
  - dmem_addr=0x1000, we=0.
  - memload=0xFFFF_FFFF_FFFF_FF88.
  - stall high for 2 cycles.
- **LHU, zero-extended:** LHU, addr=0x16, rdata=0xABCD_0000_0000_0000.
  - dmem_addr=0x10.
  - memload=0x0000_0000_0000_ABCD.
- **SW at offset 4:** SW, addr=0x2004, rs2=0xDEAD_BEEF_CAFE_F00D.
  - dmem_addr=0x2000, we=1, be=0xF0.
  - wdata=0xCAFE_F00D_CAFE_F00D.
  - memload unchanged.
- **Misaligned LW:** LW, addr=0x3002.
  - misaligned=1, req stays 0, stall=0.
- **Wait states:** LD with ack delayed 3 cycles.
  - req and addr held stable for 4 REQ cycles.
  - stall=1 for 5 cycles.
  - memload=rdata.
  - Exactly one request issued.
- **Reset mid-operation:** assert reset during REQ.
  - req=0 and FSM=IDLE immediately.
  - An ack pulse arriving afterwards leaves memload=0.
